// File: rtl/controlador_jogadas.sv
// controlador_jogadas: asks the move generator for candidate squares, rejects occupied or
// repeated ones, retries up to MAX_TENT times and delivers the accepted square through a
// pronto/ack handshake (erro/ack when the attempts run out).
module controlador_jogadas #(
  parameter int unsigned MAX_TENT = 8,  // 1..15
  parameter int unsigned GEN_LAT  = 2   // 1..15
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pedir,
  input  logic       ack,
  input  logic [2:0] linha_g,
  input  logic [2:0] coluna_g,
  input  logic       ocupada,
  output logic       novaJogada,
  output logic [2:0] linha,
  output logic [2:0] coluna,
  output logic       pronto,
  output logic       erro,
  output logic [3:0] tentativas,
  output logic [2:0] db_estado
);

  typedef enum logic [2:0] {
    Ocioso   = 3'd0,
    Gera     = 3'd1,
    Espera   = 3'd2,
    Consulta = 3'd3,
    Entrega  = 3'd4,
    Falha    = 3'd5
  } estado_t;

  localparam logic [3:0] MaxTent = 4'(MAX_TENT);
  localparam logic [3:0] LatIni  = 4'(GEN_LAT - 1);

  estado_t    estado;
  logic [3:0] contEspera;
  logic       temUltima;
  logic       repetida;
  logic       rejeita;

  // Candidate is rejected when occupied or identical to the last delivered move.
  always_comb begin
    repetida = temUltima && (linha_g == linha) && (coluna_g == coluna);
    rejeita  = ocupada || repetida;
  end

  assign db_estado = estado;

  // Sequencer FSM; every output is registered and set on the transition into its state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado     <= Ocioso;
      novaJogada <= 1'b0;
      linha      <= 3'd0;
      coluna     <= 3'd0;
      pronto     <= 1'b0;
      erro       <= 1'b0;
      tentativas <= 4'd0;
      contEspera <= 4'd0;
      temUltima  <= 1'b0;
    end else begin
      case (estado)
        Ocioso: begin
          if (pedir) begin
            estado     <= Gera;
            tentativas <= 4'd0;
            novaJogada <= 1'b1;
          end
        end
        Gera: begin
          novaJogada <= 1'b0;
          tentativas <= tentativas + 4'd1;
          contEspera <= LatIni;
          // With a single-cycle generator there is nothing left to wait for.
          if (GEN_LAT == 1) estado <= Consulta;
          else              estado <= Espera;
        end
        Espera: begin
          // Leave on the cycle the counter would reach zero.
          contEspera <= contEspera - 4'd1;
          if (contEspera == 4'd1) estado <= Consulta;
        end
        Consulta: begin
          if (!rejeita) begin
            linha     <= linha_g;
            coluna    <= coluna_g;
            temUltima <= 1'b1;
            pronto    <= 1'b1;
            estado    <= Entrega;
          end else if (tentativas < MaxTent) begin
            novaJogada <= 1'b1;
            estado     <= Gera;
          end else begin
            erro   <= 1'b1;
            estado <= Falha;
          end
        end
        Entrega: begin
          if (ack) begin
            pronto <= 1'b0;
            estado <= Ocioso;
          end
        end
        Falha: begin
          if (ack) begin
            erro   <= 1'b0;
            estado <= Ocioso;
          end
        end
        default: begin
          novaJogada <= 1'b0;
          pronto     <= 1'b0;
          erro       <= 1'b0;
          estado     <= Ocioso;
        end
      endcase
    end
  end

endmodule

// File: doc/controlador_jogadas.md
Name: controlador_jogadas

Overview:
- Sequencer that sits between the game FSM and the pseudo-random move generator (gerador_jogadas).
- On a request it pulses novaJogada, waits for the generator outputs to settle, and checks the candidate square against board occupancy and the previously delivered move.
- It retries on rejection and hands the accepted square to the consumer with a valid/ack handshake. If the retry budget is exhausted it reports an error.

Parameters:
- MAX_TENT, 8: maximum generator attempts per request, range 1..15.
- GEN_LAT, 2: cycles waited after the novaJogada pulse before sampling the generator, range 1..15.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- pedir  in  1  request for a new move; sampled only in OCIOSO.
- ack  in  1  consumer acknowledge; sampled only in ENTREGA or FALHA.
- linha_g  in  3  generator row output.
- coluna_g  in  3  generator column output.
- ocupada  in  1  board occupancy of (linha_g, coluna_g); combinational, valid in the same cycle.
- novaJogada  out  1  one-cycle pulse to the generator.
- linha  out  3  accepted row, registered.
- coluna  out  3  accepted column, registered.
- pronto  out  1  accepted move valid.
- erro  out  1  retries exhausted.
- tentativas  out  4  attempts used by the current or last request.
- db_estado  out  3  state code for debug.

Behaviour:
- Reset values: novaJogada=0, linha=0, coluna=0, pronto=0, erro=0, tentativas=0, state OCIOSO.
- Reset also clears the last-move register and its valid flag (tem_ultima=0).
- Reset asserted mid-operation aborts immediately; no pulse or handshake completes.
- State codes: OCIOSO=0, GERA=1, ESPERA=2, CONSULTA=3, ENTREGA=4, FALHA=5.
- OCIOSO, pedir=1: go to GERA, clear tentativas to 0. pedir=0: stay.
- GERA, exactly one cycle:
  - novaJogada=1 in this state only (Moore output).
  - tentativas increments by 1 on exit.
  - Load the wait counter with GEN_LAT-1, then go to ESPERA.
- ESPERA: decrement the wait counter; when it reaches 0 go to CONSULTA. Time from novaJogada high to the CONSULTA cycle is exactly GEN_LAT cycles.
- CONSULTA, one cycle. A candidate is rejected if:
  - ocupada=1, or
  - tem_ultima=1 and (linha_g, coluna_g) equals (linha, coluna).
- CONSULTA transitions:
  - Accepted: register linha<=linha_g and coluna<=coluna_g, set tem_ultima=1, go to ENTREGA.
  - Rejected with tentativas<MAX_TENT: go to GERA.
  - Rejected with tentativas==MAX_TENT: go to FALHA.
- ENTREGA: pronto=1, with linha/coluna held stable until ack. On ack=1 go to OCIOSO; pronto falls the next cycle.
- FALHA: erro=1, linha/coluna unchanged (previous move). On ack=1 go to OCIOSO.
- Handshake rules:
  - pedir while busy is ignored; it is not queued.
  - ack outside ENTREGA/FALHA is ignored.
  - pedir and ack in the same cycle while in ENTREGA: ack wins, return to OCIOSO. pedir is re-sampled there on the next cycle.
- tentativas holds its value after completion until the next accepted pedir. It never exceeds MAX_TENT.
- Minimum latency pedir to pronto, first attempt accepted: 1 (GERA) + GEN_LAT-1 (ESPERA) + 1 (CONSULTA) + 1 = GEN_LAT+2 cycles.
- Default GEN_LAT=2: pronto is high 4 cycles after the pedir edge.

Test Plan:
- Basic accept: after reset, pedir=1 for 1 cycle; stub linha_g=3, coluna_g=5, ocupada=0. Expect one novaJogada pulse, pronto=1 exactly 4 cycles later with linha=3, coluna=5, tentativas=1. ack → pronto=0 next cycle, state 0.
- Occupied retry: stub returns (2,2) occupied, then (4,1) free on the 2nd pulse. Expect 2 novaJogada pulses, pronto with (4,1), tentativas=2.
- Repeat rejection: after delivering (3,5), the next request's stub returns (3,5) then (6,0), ocupada=0. Expect (3,5) rejected and (6,0) delivered, tentativas=2.
- Exhaustion: ocupada held at 1. Expect exactly 8 novaJogada pulses, erro=1, pronto=0, tentativas=8, linha/coluna unchanged. ack → OCIOSO, erro=0.
- Reset mid-operation: assert reset in ESPERA of the 3rd attempt. Expect all outputs 0 asynchronously. A following pedir with stub (3,5) is accepted; tem_ultima was cleared, so no repeat rejection.
- Handshake corners: pedir pulsed while in ENTREGA, and ack while OCIOSO. Expect both ignored. pedir+ack together in ENTREGA → OCIOSO, with no new novaJogada unless pedir is still high the next cycle.
